// File: rtl/veripg_arb_pkg.sv
// rtl/veripg_arb_pkg.sv - shared types and round-robin helper for the pipe arbiter
package veripg_arb_pkg;

    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef logic [MAX_ID_W:0] pick_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    // Returns {found, index} of the first set bit of valid at or after ptr,
    // wrapping modulo n. Walks offsets from high to low so the smallest
    // offset from ptr is the last (winning) assignment.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input pick_t               n
    );
        pick_t res;
        pick_t idx;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + pick_t'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((pick_t'(k) < n) && valid[idx[MAX_ID_W-1:0]]) begin
                res = {1'b1, idx[MAX_ID_W-1:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/veripg_datapath.sv
// rtl/veripg_datapath.sv - fixed-latency pass-through datapath pipeline
module veripg_datapath #(
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out
);

    logic [DATA_WIDTH-1:0] data_q  [PIPE_DEPTH];
    logic                  valid_q [PIPE_DEPTH];

    assign data_out  = data_q[PIPE_DEPTH-1];
    assign valid_out = valid_q[PIPE_DEPTH-1];

    // Shift payload and valid through PIPE_DEPTH register stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                data_q[k]  <= '0;
                valid_q[k] <= 1'b0;
            end
        end else begin
            data_q[0]  <= data_in;
            valid_q[0] <= valid_in;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

endmodule

// File: rtl/veripg_rsp_fifo.sv
// rtl/veripg_rsp_fifo.sv - first-word fall-through response FIFO
module veripg_rsp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    // Head reads as zero while empty so the response bus idles at zero.
    assign pop_data = empty ? '0 : mem[rd_q];

    // Pointer and occupancy update; a push into a full FIFO is taken only alongside a pop.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = do_push ? next_ptr(wr_q) : wr_q;
        rd_d    = do_pop ? next_ptr(rd_q) : rd_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= push_data;
        end
    end

endmodule

// File: rtl/veripg_pipe_arbiter.sv
// rtl/veripg_pipe_arbiter.sv - round-robin, credit-limited arbiter in front of a fixed-latency datapath
module veripg_pipe_arbiter
    import veripg_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_DEPTH = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         dp_data_in,
    output logic                          dp_valid_in,
    input  logic [DATA_WIDTH-1:0]         dp_data_out,
    input  logic                          dp_valid_out,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic                          drain_req,
    output logic                          drain_done
);

    localparam int    ID_W   = $clog2(NUM_REQ);
    localparam int    CRD_W  = $clog2(RSP_DEPTH + 1);
    localparam int    FIFO_W = ID_W + DATA_WIDTH;
    localparam pick_t N_REQ  = pick_t'(NUM_REQ);

    arb_state_e            state_q, state_d;
    logic                  drain_done_q;
    logic [MAX_ID_W-1:0]   ptr_q, ptr_d;
    logic [CRD_W-1:0]      credits_q, credits_d;
    logic                  dp_valid_q, dp_valid_d;
    logic [DATA_WIDTH-1:0] dp_data_q, dp_data_d;
    logic [MAX_ID_W-1:0]   issue_id_q, issue_id_d;
    tag_t                  tag_q [PIPE_DEPTH];
    tag_t                  tag_d [PIPE_DEPTH];
    tag_t                  tag_out;

    logic [MAX_REQ-1:0]    valid_ext, grant_oh;
    pick_t                 pick;
    logic [MAX_ID_W-1:0]   pick_idx;
    logic                  grant_en, accept, pop, pipe_busy;

    logic                  fifo_full, fifo_empty;
    logic [CRD_W-1:0]      fifo_count;
    logic [FIFO_W-1:0]     fifo_push_data, fifo_pop_data;

    assign dp_valid_in          = dp_valid_q;
    assign dp_data_in           = dp_data_q;
    assign drain_done           = drain_done_q;
    assign tag_out              = tag_q[PIPE_DEPTH-1];
    assign rsp_valid            = !fifo_empty;
    assign pop                  = rsp_valid && rsp_ready;
    assign {rsp_id, rsp_data}   = fifo_pop_data;
    assign fifo_push_data       = {tag_out.id[ID_W-1:0], dp_data_out};

    // Round-robin pick; a grant needs RUN, a free credit and reset released.
    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        pick                     = rr_pick(valid_ext, ptr_q, N_REQ);
        pick_idx                 = pick[MAX_ID_W-1:0];
        grant_en                 = !rst && (state_q == RUN) && (credits_q != '0) && pick[MAX_ID_W];
        grant_oh                 = '0;
        if (grant_en) begin
            grant_oh[pick_idx] = 1'b1;
        end
        req_ready = grant_oh[NUM_REQ-1:0];
        accept    = grant_en;
    end

    // Next-state for pointer, credits, issue register and tag shift.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (pick_idx == MAX_ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end

        credits_d = credits_q;
        if (accept && !pop) begin
            credits_d = credits_q - 1'b1;
        end else if (pop && !accept) begin
            credits_d = credits_q + 1'b1;
        end

        dp_valid_d = accept;
        dp_data_d  = dp_data_q;
        issue_id_d = issue_id_q;
        if (accept) begin
            issue_id_d = pick_idx;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_oh[i]) begin
                    dp_data_d = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end

        tag_d[0] = '{valid: dp_valid_q, id: issue_id_q};
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        pipe_busy = dp_valid_q;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            pipe_busy = pipe_busy | tag_q[k].valid;
        end
    end

    // Drain state transitions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req) state_d = DRAIN;
            DRAIN: begin
                if (!drain_req) begin
                    state_d = RUN;
                end else if (!pipe_busy && fifo_empty) begin
                    state_d = DRAINED;
                end
            end
            DRAINED: if (!drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Drain FSM with registered drain_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_done_q <= (state_d == DRAINED);
        end
    end

    // Arbitration, credit, issue and tag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            credits_q  <= CRD_W'(RSP_DEPTH);
            dp_valid_q <= 1'b0;
            dp_data_q  <= '0;
            issue_id_q <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            credits_q  <= credits_d;
            dp_valid_q <= dp_valid_d;
            dp_data_q  <= dp_data_d;
            issue_id_q <= issue_id_d;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    veripg_rsp_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (RSP_DEPTH),
        .CNT_W (CRD_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (dp_valid_out),
        .push_data (fifo_push_data),
        .pop       (pop),
        .pop_data  (fifo_pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The datapath must return exactly the beats the tag pipeline expects.
    assert property (@(posedge clk) disable iff (rst) dp_valid_out == tag_out.valid);

    // Credits guarantee the FIFO never has to drop a result.
    assert property (@(posedge clk) disable iff (rst) !(fifo_full && dp_valid_out && !pop));
    assert property (@(posedge clk) disable iff (rst) (int'(fifo_count) + int'(credits_q)) <= RSP_DEPTH);

endmodule
